// File: rtl/detect_frame_sequencer.sv
// detect_frame_sequencer
//   Holds one IMG_WIDTH x IMG_HEIGHT frame and replays it to a face detector:
//   start pulse, raster-order stream with valid/ready and optional row gaps,
//   then a watchdog-guarded wait for done. Repeats for num_frames_i frames.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   wr_en_i/addr_i/data_i      frame memory write port (honoured only when idle)
//   run_i, num_frames_i        start a run (0 frames = continuous), abort_i stops it
//   det_start_o, pixel_*       detector stream interface
//   det_done_i, det_*_i        detector result inputs
//   busy_o, frame_done_o       status; res_*_o last captured result
//   frames_done_o, face_count_o, timeout_err_o  run statistics
module detect_frame_sequencer #(
    parameter int unsigned IMG_WIDTH      = 64,
    parameter int unsigned IMG_HEIGHT     = 64,
    parameter int unsigned PIXEL_WIDTH    = 8,
    parameter int unsigned ROW_GAP        = 0,
    parameter int unsigned TIMEOUT_CYCLES = 9000000,
    parameter int unsigned AW             = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [AW-1:0]          wr_addr_i,
    input  logic [PIXEL_WIDTH-1:0] wr_data_i,
    input  logic                   run_i,
    input  logic [7:0]             num_frames_i,
    input  logic                   abort_i,
    output logic                   det_start_o,
    output logic [PIXEL_WIDTH-1:0] pixel_out_o,
    output logic                   pixel_valid_o,
    input  logic                   pixel_ready_i,
    input  logic                   det_done_i,
    input  logic                   det_face_i,
    input  logic [7:0]             det_x_i,
    input  logic [7:0]             det_y_i,
    input  logic [7:0]             det_scale_i,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic                   res_face_o,
    output logic [7:0]             res_x_o,
    output logic [7:0]             res_y_o,
    output logic [7:0]             res_scale_o,
    output logic [7:0]             frames_done_o,
    output logic [7:0]             face_count_o,
    output logic                   timeout_err_o
);

    localparam int unsigned NumPix = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned XW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    typedef enum logic [2:0] {StIdle, StStart, StStream, StGap, StWaitDone, StCapture} state_e;

    state_e                   state_q, state_d;
    logic [AW-1:0]            addr_q, addr_d;
    logic [XW-1:0]            x_q, x_d;
    logic [31:0]              gap_cnt_q, gap_cnt_d;
    logic [31:0]              wd_cnt_q, wd_cnt_d;
    logic                     done_seen_q, done_seen_d;
    logic [7:0]               num_frames_q, num_frames_d;
    logic [7:0]               frames_done_q, frames_done_d;
    logic [7:0]               face_count_q, face_count_d;
    logic                     timeout_err_q, timeout_err_d;
    logic                     frame_done_q, frame_done_d;
    logic                     res_face_q, res_face_d;
    logic [7:0]               res_x_q, res_x_d, res_y_q, res_y_d, res_scale_q, res_scale_d;
    logic                     latch_res;
    logic                     last_pix, row_end;
    logic [7:0]               frames_inc;
    logic [PIXEL_WIDTH-1:0]   mem [NumPix];

    // Frame memory: writable only while idle so a running stream never tears.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && state_q == StIdle) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign last_pix   = (addr_q == AW'(NumPix - 1));
    assign row_end    = (x_q == XW'(IMG_WIDTH - 1));
    assign frames_inc = (frames_done_q == 8'hFF) ? 8'hFF : frames_done_q + 8'd1;

    assign det_start_o   = (state_q == StStart);
    assign pixel_valid_o = (state_q == StStream);
    assign pixel_out_o   = pixel_valid_o ? mem[addr_q] : '0;
    assign busy_o        = (state_q != StIdle);
    assign frame_done_o  = frame_done_q;
    assign res_face_o    = res_face_q;
    assign res_x_o       = res_x_q;
    assign res_y_o       = res_y_q;
    assign res_scale_o   = res_scale_q;
    assign frames_done_o = frames_done_q;
    assign face_count_o  = face_count_q;
    assign timeout_err_o = timeout_err_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        x_d           = x_q;
        gap_cnt_d     = '0;
        wd_cnt_d      = '0;
        done_seen_d   = done_seen_q;
        num_frames_d  = num_frames_q;
        frames_done_d = frames_done_q;
        face_count_d  = face_count_q;
        timeout_err_d = timeout_err_q;
        frame_done_d  = 1'b0;
        res_face_d    = res_face_q;
        res_x_d       = res_x_q;
        res_y_d       = res_y_q;
        res_scale_d   = res_scale_q;
        latch_res     = 1'b0;

        if (abort_i) begin
            // Abort wins over everything: results and counters hold.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (run_i) begin
                        num_frames_d  = num_frames_i;
                        frames_done_d = '0;
                        face_count_d  = '0;
                        timeout_err_d = 1'b0;
                        done_seen_d   = 1'b0;
                        state_d       = StStart;
                    end
                end
                StStart: begin
                    addr_d  = '0;
                    x_d     = '0;
                    state_d = StStream;
                    if (det_done_i) begin
                        latch_res   = 1'b1;
                        done_seen_d = 1'b1;
                    end
                end
                StStream: begin
                    if (det_done_i) begin
                        latch_res   = 1'b1;
                        done_seen_d = 1'b1;
                    end
                    if (pixel_ready_i) begin
                        addr_d = addr_q + AW'(1);
                        x_d    = row_end ? '0 : x_q + XW'(1);
                        if (last_pix) begin
                            // A done that arrived during streaming skips the wait.
                            state_d = (done_seen_q || det_done_i) ? StCapture : StWaitDone;
                        end else if (row_end && ROW_GAP > 0) begin
                            state_d = StGap;
                        end
                    end
                end
                StGap: begin
                    if (det_done_i) begin
                        latch_res   = 1'b1;
                        done_seen_d = 1'b1;
                    end
                    if (gap_cnt_q == 32'(ROW_GAP - 1)) begin
                        state_d = StStream;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 32'd1;
                    end
                end
                StWaitDone: begin
                    if (det_done_i) begin
                        latch_res = 1'b1;
                        state_d   = StCapture;
                    end else if (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err_d = 1'b1;
                        res_face_d    = 1'b0;
                        frame_done_d  = 1'b1;
                        frames_done_d = frames_inc;
                        state_d       = StIdle;
                    end else begin
                        wd_cnt_d = wd_cnt_q + 32'd1;
                    end
                end
                StCapture: begin
                    frame_done_d  = 1'b1;
                    frames_done_d = frames_inc;
                    if (res_face_q && face_count_q != 8'hFF) begin
                        face_count_d = face_count_q + 8'd1;
                    end
                    if (num_frames_q != 8'd0 &&
                        ({1'b0, frames_done_q} + 9'd1) >= {1'b0, num_frames_q}) begin
                        state_d = StIdle;
                    end else begin
                        done_seen_d = 1'b0;
                        state_d     = StStart;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (latch_res) begin
            res_face_d  = det_face_i;
            res_x_d     = det_x_i;
            res_y_d     = det_y_i;
            res_scale_d = det_scale_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            x_q           <= '0;
            gap_cnt_q     <= '0;
            wd_cnt_q      <= '0;
            done_seen_q   <= 1'b0;
            num_frames_q  <= '0;
            frames_done_q <= '0;
            face_count_q  <= '0;
            timeout_err_q <= 1'b0;
            frame_done_q  <= 1'b0;
            res_face_q    <= 1'b0;
            res_x_q       <= '0;
            res_y_q       <= '0;
            res_scale_q   <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            x_q           <= x_d;
            gap_cnt_q     <= gap_cnt_d;
            wd_cnt_q      <= wd_cnt_d;
            done_seen_q   <= done_seen_d;
            num_frames_q  <= num_frames_d;
            frames_done_q <= frames_done_d;
            face_count_q  <= face_count_d;
            timeout_err_q <= timeout_err_d;
            frame_done_q  <= frame_done_d;
            res_face_q    <= res_face_d;
            res_x_q       <= res_x_d;
            res_y_q       <= res_y_d;
            res_scale_q   <= res_scale_d;
        end
    end

endmodule
